gray_to_bin_decoder: RTL and testbench



---
 rtl/gray_to_bin_decoder.sv | 130 +++++++++++++
 tb/tb_gray_to_bin_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gray_to_bin_decoder.sv
// rtl/gray_to_bin_decoder.sv - registered Gray-to-binary decoder with step classification
//
// Purpose:
//   Decodes a Gray-coded word accepted on a valid/ready handshake into binary,
//   registered one cycle later. Each accepted word is classified against the
//   previously accepted word as hold / up / down / first-after-reset. A jump of
//   more than one position (mod 2^WIDTH) raises step_err and bumps a saturating
//   error counter.
//
// Build option:
//   GRAY_DEC_STEP_CHECK_EN - when defined, builds the previous-word tracking,
//   dir, step_err and err_count logic. When undefined, those outputs are tied
//   to 0 and only decode plus handshake remain.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   gray_in holds a word
//   gray_in    in   [WIDTH-1:0] Gray-coded word
//   in_ready   out  decoder can accept this cycle
//   out_valid  out  bin_out / status valid
//   out_ready  in   consumer accepts the output word
//   bin_out    out  [WIDTH-1:0] decoded binary value
//   dir        out  [1:0] 00 hold, 01 up, 10 down, 11 first word after reset
//   step_err   out  accepted word not within +/-1 of the previous word
//   err_count  out  [ERRW-1:0] saturating count of step_err events

module gray_to_bin_decoder #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic [1:0]       dir,
  output logic             step_err,
  output logic [ERRW-1:0]  err_count
);

  logic             accept;
  logic [WIDTH-1:0] bin_dec;

  // Single output register: a new word may enter whenever the slot is empty
  // or is being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Each binary bit is the XOR of all Gray bits at or above it; this is the
  // unrolled form of bin[i] = bin[i+1] ^ g[i] without a combinational chain
  // through a shared vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_decode
    assign bin_dec[i] = ^gray_in[WIDTH-1:i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bin_out   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bin_out   <= bin_dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_DEC_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_bin;
  logic             have_prev;
  logic [WIDTH-1:0] delta;
  logic [1:0]       dir_nxt;
  logic             err_nxt;
  logic [1:0]       dir_q;
  logic             step_err_q;
  logic [ERRW-1:0]  err_count_q;

  // Modular difference makes max->0 an up step and 0->max a down step.
  assign delta = bin_dec - prev_bin;

  always_comb begin
    dir_nxt = 2'b00;
    err_nxt = 1'b0;
    if (!have_prev) begin
      dir_nxt = 2'b11;
    end else if (delta == '0) begin
      dir_nxt = 2'b00;
    end else if (delta == WIDTH'(1)) begin
      dir_nxt = 2'b01;
    end else if (delta == '1) begin
      dir_nxt = 2'b10;
    end else begin
      err_nxt = 1'b1;
    end
  end

  // Tracking follows every accept, even a flagged one, so a single glitch
  // produces one error rather than an error on every following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bin    <= '0;
      have_prev   <= 1'b0;
      dir_q       <= 2'b00;
      step_err_q  <= 1'b0;
      err_count_q <= '0;
    end else if (accept) begin
      prev_bin   <= bin_dec;
      have_prev  <= 1'b1;
      dir_q      <= dir_nxt;
      step_err_q <= err_nxt;
      if (err_nxt && (err_count_q != {ERRW{1'b1}})) begin
        err_count_q <= err_count_q + ERRW'(1);
      end
    end
  end

  assign dir       = dir_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;
`else
  assign dir       = 2'b00;
  assign step_err  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_gray_to_bin_decoder.sv
// tb/tb_gray_to_bin_decoder.sv - self-checking bench for gray_to_bin_decoder

module tb_gray_to_bin_decoder;

  localparam int WIDTH = 4;
  localparam int ERRW  = 8;
  localparam int NVAL  = 1 << WIDTH;
`ifdef GRAY_DEC_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] gray_in = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] bin_out;
  logic [1:0]       dir;
  logic             step_err;
  logic [ERRW-1:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  gray_to_bin_decoder #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .dir(dir), .step_err(step_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inverse found by searching the forward encoding b ^ (b >> 1).
  function automatic int gray_inv(input int g);
    for (int b = 0; b < NVAL; b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & (NVAL - 1);
  endfunction

  // Reference model state: what the outputs must show after the latest edge.
  bit started = 0;
  bit m_valid = 0;
  int m_bin = 0, m_dir = 0, m_err = 0, m_cnt = 0, m_prev = 0;
  bit m_have = 0;

  always @(posedge clk) begin
    bit rdy;
    int b, d;
    if (rst) begin
      started = 1;
      m_valid = 0; m_bin = 0; m_dir = 0; m_err = 0; m_cnt = 0;
      m_prev = 0; m_have = 0;
    end else if (started) begin
      rdy = !m_valid || out_ready;
      if (in_valid && rdy) begin
        b = gray_inv(int'(gray_in));
        d = (b - m_prev + NVAL) % NVAL;
        m_err = 0;
        if (!m_have)               m_dir = 3;
        else if (d == 0)           m_dir = 0;
        else if (d == 1)           m_dir = 1;
        else if (d == NVAL - 1)    m_dir = 2;
        else begin m_dir = 0; m_err = 1; end
        if (m_err == 1 && m_cnt < (1 << ERRW) - 1) m_cnt++;
        m_prev = b; m_have = 1; m_bin = b; m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare process: every cycle on the falling edge, well clear of the
  // input changes (posedge + 2) and the DUT's register updates.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("err_count", int'(err_count), CHK ? m_cnt : 0);
      if (m_valid) begin
        chk("bin_out", int'(bin_out), m_bin);
        chk("dir", int'(dir), CHK ? m_dir : 0);
        chk("step_err", int'(step_err), CHK ? m_err : 0);
      end
    end
  end

  task automatic step(input bit v, input int g, input bit r, input bit rs = 0);
    @(posedge clk);
    #2;
    rst = rs; in_valid = v; gray_in = WIDTH'(g); out_ready = r;
  endtask

  int cur;

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_step_err", int'(step_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Exhaustive decode sweep, one Gray-adjacent step per cycle.
    for (int b = 0; b < NVAL; b++) step(1, to_gray(b), 1);
    step(0, 0, 0);
    @(negedge clk);
    chk("pin_1000_to_1111", int'(bin_out), 15);

    // Wrap both ways.
    step(1, 4'b1000, 1);
    step(1, 4'b0000, 1);
    step(1, 4'b1000, 1);
    step(0, 0, 1);

    // Illegal jump from a clean reset.
    step(0, 0, 1, 1);
    step(1, 4'b0000, 1);
    step(1, 4'b0110, 1);
    step(0, 0, 0);
    @(negedge clk);
    chk("pin_0110_to_0100", int'(bin_out), 4);
    chk("pin_jump_step_err", int'(step_err), CHK ? 1 : 0);
    chk("pin_jump_dir", int'(dir), 0);
    chk("pin_jump_err_count", int'(err_count), CHK ? 1 : 0);
    step(1, 4'b0111, 1);
    step(0, 0, 0);
    @(negedge clk);
    chk("pin_after_jump_dir", int'(dir), CHK ? 1 : 0);
    chk("pin_after_jump_bin", int'(bin_out), 5);

    // Backpressure with a continuously offered word, then release.
    step(1, 4'b0101, 0);
    step(1, 4'b0101, 0);
    step(1, 4'b0101, 0);
    step(1, 4'b0100, 1);
    step(0, 0, 1);

    // Randomised traffic, mostly Gray-adjacent with occasional jumps.
    cur = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(9) < 7) cur = (cur + int'($urandom_range(2)) - 1 + NVAL) % NVAL;
      else cur = int'($urandom_range(NVAL - 1));
      step($urandom_range(3) != 0, to_gray(cur), $urandom_range(3) != 0, $urandom_range(199) == 0);
    end

    // Saturation of the error counter, then reset mid-stream.
    step(0, 0, 1, 1);
    for (int i = 0; i < 300; i++) step(1, (i % 2) ? 4'b0110 : 4'b0000, 1);
    step(0, 0, 1);
    @(negedge clk);
    chk("pin_saturated", int'(err_count), CHK ? 255 : 0);
    step(1, 4'b0110, 1);
    step(1, 4'b0000, 1, 1);
    step(0, 0, 1);
    @(negedge clk);
    chk("pin_mid_rst_valid", int'(out_valid), 0);
    chk("pin_mid_rst_bin", int'(bin_out), 0);
    chk("pin_mid_rst_count", int'(err_count), 0);
    step(1, 4'b0011, 1);
    step(0, 0, 0);
    @(negedge clk);
    chk("pin_first_after_rst", int'(dir), CHK ? 3 : 0);
    chk("pin_first_after_rst_bin", int'(bin_out), 2);

    step(0, 0, 1);
    step(0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
